// File: rtl/atomic_unit.sv
// RV32A atomic execution engine in the MEM stage: LR.W, SC.W and AMO*.W as a
// read-modify-write over a req/ack memory port, plus the single-hart LR/SC reservation.
module atomic_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  is_atomic_mem,
  input  logic [4:0]            amo_fun5_mem,
  input  logic [ADDR_WIDTH-1:0] addr_mem,
  input  logic [XLEN-1:0]       rs2_data_mem,
  input  logic                  store_mem,
  input  logic                  mem_advance,
  input  logic                  trap,
  output logic                  atomic_unit_stall,
  output logic                  amo_req,
  output logic                  amo_we,
  output logic [ADDR_WIDTH-1:0] amo_addr,
  output logic [XLEN-1:0]       amo_wdata,
  input  logic                  amo_ack,
  input  logic [XLEN-1:0]       amo_rdata,
  output logic [XLEN-1:0]       amo_result,
  output logic                  amo_misaligned
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [4:0] F_LR   = 5'b00010;
  localparam logic [4:0] F_SC   = 5'b00011;
  localparam logic [4:0] F_ADD  = 5'b00000;
  localparam logic [4:0] F_XOR  = 5'b00100;
  localparam logic [4:0] F_AND  = 5'b01100;
  localparam logic [4:0] F_OR   = 5'b01000;
  localparam logic [4:0] F_MIN  = 5'b10000;
  localparam logic [4:0] F_MAX  = 5'b10100;
  localparam logic [4:0] F_MINU = 5'b11000;
  localparam logic [4:0] F_MAXU = 5'b11100;

  state_t                state, state_nxt;
  logic                  resv_vld, resv_set, resv_clr;
  logic [ADDR_WIDTH-3:0] resv_addr;
  logic [ADDR_WIDTH-3:0] word;
  logic [XLEN-1:0]       result_nxt, wdata_nxt, alu;
  logic                  is_lr, is_sc, resv_hit;

  assign word     = addr_mem[ADDR_WIDTH-1:2];
  assign is_lr    = (amo_fun5_mem == F_LR);
  assign is_sc    = (amo_fun5_mem == F_SC);
  assign resv_hit = resv_vld && (resv_addr == word);

  assign amo_misaligned    = is_atomic_mem && (addr_mem[1:0] != 2'b00) && (state == IDLE);
  assign atomic_unit_stall = is_atomic_mem && !amo_misaligned && (state != DONE);
  assign amo_req           = (state == READ) || (state == WRITE);
  assign amo_we            = (state == WRITE);
  assign amo_addr          = {word, 2'b00};

  // Modify step; unknown encodings fall through to swap.
  always_comb begin
    alu = rs2_data_mem;
    case (amo_fun5_mem)
      F_ADD:   alu = amo_rdata + rs2_data_mem;
      F_XOR:   alu = amo_rdata ^ rs2_data_mem;
      F_AND:   alu = amo_rdata & rs2_data_mem;
      F_OR:    alu = amo_rdata | rs2_data_mem;
      F_MIN:   alu = ($signed(amo_rdata) < $signed(rs2_data_mem)) ? amo_rdata : rs2_data_mem;
      F_MAX:   alu = ($signed(amo_rdata) > $signed(rs2_data_mem)) ? amo_rdata : rs2_data_mem;
      F_MINU:  alu = (amo_rdata < rs2_data_mem) ? amo_rdata : rs2_data_mem;
      F_MAXU:  alu = (amo_rdata > rs2_data_mem) ? amo_rdata : rs2_data_mem;
      default: alu = rs2_data_mem;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    result_nxt = amo_result;
    wdata_nxt  = amo_wdata;
    resv_set   = 1'b0;
    resv_clr   = 1'b0;
    case (state)
      IDLE: if (is_atomic_mem && !amo_misaligned) begin
        if (is_sc) begin
          resv_clr = 1'b1;
          if (resv_hit) begin
            state_nxt = WRITE;
            wdata_nxt = rs2_data_mem;
          end else begin
            state_nxt  = DONE;
            result_nxt = {{(XLEN-1){1'b0}}, 1'b1};
          end
        end else begin
          state_nxt = READ;
        end
      end
      READ: if (amo_ack) begin
        result_nxt = amo_rdata;
        if (is_lr) begin
          resv_set  = 1'b1;
          state_nxt = DONE;
        end else begin
          wdata_nxt = alu;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        resv_clr = 1'b1;
        if (amo_ack) begin
          state_nxt = DONE;
          if (is_sc) result_nxt = '0;
        end
      end
      DONE: if (mem_advance) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Traps and plain stores to the reserved word kill the reservation in any state.
    if (trap) resv_clr = 1'b1;
    if (store_mem && resv_hit) resv_clr = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      resv_vld   <= 1'b0;
      resv_addr  <= '0;
      amo_result <= '0;
      amo_wdata  <= '0;
    end else begin
      state      <= state_nxt;
      amo_result <= result_nxt;
      amo_wdata  <= wdata_nxt;
      if (resv_clr)      resv_vld <= 1'b0;
      else if (resv_set) resv_vld <= 1'b1;
      if (resv_set) resv_addr <= word;
    end
  end

endmodule

// File: tb/tb_atomic_unit.sv
// Directed bench for atomic_unit: behavioural memory with programmable ack delay.
module tb_atomic_unit;

  localparam logic [4:0] F_LR   = 5'b00010;
  localparam logic [4:0] F_SC   = 5'b00011;
  localparam logic [4:0] F_SWAP = 5'b00001;
  localparam logic [4:0] F_ADD  = 5'b00000;
  localparam logic [4:0] F_XOR  = 5'b00100;
  localparam logic [4:0] F_AND  = 5'b01100;
  localparam logic [4:0] F_OR   = 5'b01000;
  localparam logic [4:0] F_MIN  = 5'b10000;
  localparam logic [4:0] F_MAX  = 5'b10100;
  localparam logic [4:0] F_MINU = 5'b11000;
  localparam logic [4:0] F_MAXU = 5'b11100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        is_atomic_mem, store_mem, mem_advance, trap;
  logic [4:0]  amo_fun5_mem;
  logic [31:0] addr_mem, rs2_data_mem;
  logic        stall, amo_req, amo_we, amo_ack, amo_misaligned;
  logic [31:0] amo_addr, amo_wdata, amo_rdata, amo_result;

  logic [31:0] mem [0:1023];
  int          ack_delay, wait_cnt;
  int          n_rd, n_wr, n_req, n_unst;
  logic [31:0] last_raddr, last_waddr, last_wdata;
  logic        p_pend, p_we;
  logic [31:0] p_addr, p_wd;
  int          n_tests = 0, n_fail = 0;
  int          st;

  atomic_unit #(.ADDR_WIDTH(32), .XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .is_atomic_mem(is_atomic_mem),
    .amo_fun5_mem(amo_fun5_mem), .addr_mem(addr_mem), .rs2_data_mem(rs2_data_mem),
    .store_mem(store_mem), .mem_advance(mem_advance), .trap(trap),
    .atomic_unit_stall(stall), .amo_req(amo_req), .amo_we(amo_we),
    .amo_addr(amo_addr), .amo_wdata(amo_wdata), .amo_ack(amo_ack),
    .amo_rdata(amo_rdata), .amo_result(amo_result), .amo_misaligned(amo_misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr_cnt();
    n_rd = 0; n_wr = 0; n_req = 0; n_unst = 0;
  endtask

  // Issue one atomic, wait for stall to drop, hold DONE adv_hold cycles, then advance.
  task automatic do_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] r,
                       input int adv_hold, output int stalls);
    logic [31:0] res;
    @(posedge clk); #1;
    clr_cnt();
    is_atomic_mem = 1'b1; amo_fun5_mem = f; addr_mem = a; rs2_data_mem = r;
    mem_advance = 1'b0;
    stalls = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (!stall) break;
      stalls++;
    end
    chk("done_reached", {31'b0, stall}, 32'h0);
    res = amo_result;
    for (int i = 0; i < adv_hold; i++) begin
      @(negedge clk); #1;
      chk("done_hold_stall", {31'b0, stall}, 32'h0);
      chk("done_hold_result", amo_result, res);
    end
    mem_advance = 1'b1;
    @(posedge clk); #1;
    is_atomic_mem = 1'b0; mem_advance = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a);
    @(posedge clk); #1;
    store_mem = 1'b1; addr_mem = a;
    @(posedge clk); #1;
    store_mem = 1'b0;
  endtask

  task automatic run_alu(input string tag, input logic [4:0] f, input logic [31:0] m0,
                         input logic [31:0] r, input logic [31:0] exp_w);
    int s;
    mem[32'h300 >> 2] = m0;
    do_op(f, 32'h300, r, 0, s);
    chk({tag, "_result"}, amo_result, m0);
    chk({tag, "_wdata"}, last_wdata, exp_w);
    chk({tag, "_mem"}, mem[32'h300 >> 2], exp_w);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    reset_n = 1'b0; is_atomic_mem = 1'b0; store_mem = 1'b0; mem_advance = 1'b0;
    trap = 1'b0; amo_fun5_mem = 5'b0; addr_mem = 32'h0; rs2_data_mem = 32'h0;
    amo_ack = 1'b0; amo_rdata = 32'h0; ack_delay = 0; wait_cnt = 0;
    p_pend = 1'b0; p_we = 1'b0; p_addr = 32'h0; p_wd = 32'h0;
    last_raddr = 32'h0; last_waddr = 32'h0; last_wdata = 32'h0;
    clr_cnt();

    // Memory responder: decides ack at each negedge, DUT commits on the next posedge.
    fork
      forever begin
        @(negedge clk);
        if (amo_req && wait_cnt >= ack_delay) begin
          amo_ack = 1'b1;
          amo_rdata = mem[amo_addr[11:2]];
          if (amo_we) begin
            mem[amo_addr[11:2]] = amo_wdata;
            last_waddr = amo_addr; last_wdata = amo_wdata; n_wr++;
          end else begin
            last_raddr = amo_addr; n_rd++;
          end
          wait_cnt = 0;
        end else begin
          amo_ack = 1'b0;
          amo_rdata = 32'h0;
          wait_cnt = amo_req ? wait_cnt + 1 : 0;
        end
        if (amo_req) n_req++;
        if (p_pend && amo_req && (amo_addr != p_addr || amo_we != p_we || amo_wdata != p_wd))
          n_unst++;
        p_pend = amo_req && !amo_ack;
        p_addr = amo_addr; p_we = amo_we; p_wd = amo_wdata;
      end
    join_none

    #12;
    chk("rst_req", {31'b0, amo_req}, 32'h0);
    chk("rst_we", {31'b0, amo_we}, 32'h0);
    chk("rst_result", amo_result, 32'h0);
    chk("rst_wdata", amo_wdata, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    @(posedge clk); #1; reset_n = 1'b1;

    // AMOADD, immediate ack
    mem[32'h100 >> 2] = 32'd5;
    do_op(F_ADD, 32'h100, 32'd7, 0, st);
    chk("add_stall", st, 3);
    chk("add_result", amo_result, 32'd5);
    chk("add_raddr", last_raddr, 32'h100);
    chk("add_waddr", last_waddr, 32'h100);
    chk("add_mem", mem[32'h100 >> 2], 32'd12);
    chk("add_nrd", n_rd, 1);
    chk("add_nwr", n_wr, 1);

    // LR / SC success / SC fail
    mem[32'h200 >> 2] = 32'hAB;
    do_op(F_LR, 32'h200, 32'h0, 0, st);
    chk("lr_stall", st, 2);
    chk("lr_result", amo_result, 32'hAB);
    chk("lr_nwr", n_wr, 0);
    do_op(F_SC, 32'h200, 32'h55, 0, st);
    chk("sc_stall", st, 2);
    chk("sc_result", amo_result, 32'h0);
    chk("sc_mem", mem[32'h200 >> 2], 32'h55);
    chk("sc_nrd", n_rd, 0);
    do_op(F_SC, 32'h200, 32'h99, 0, st);
    chk("sc2_stall", st, 1);
    chk("sc2_result", amo_result, 32'h1);
    chk("sc2_nreq", n_req, 0);
    chk("sc2_mem", mem[32'h200 >> 2], 32'h55);

    // Store snoop: same word kills the reservation, next word does not
    do_op(F_LR, 32'h200, 32'h0, 0, st);
    do_store(32'h203);
    do_op(F_SC, 32'h200, 32'h66, 0, st);
    chk("snoop_hit_result", amo_result, 32'h1);
    chk("snoop_hit_nwr", n_wr, 0);
    chk("snoop_hit_mem", mem[32'h200 >> 2], 32'h55);
    do_op(F_LR, 32'h200, 32'h0, 0, st);
    do_store(32'h204);
    do_op(F_SC, 32'h200, 32'h66, 0, st);
    chk("snoop_miss_result", amo_result, 32'h0);
    chk("snoop_miss_mem", mem[32'h200 >> 2], 32'h66);

    // Trap clears the reservation
    do_op(F_LR, 32'h200, 32'h0, 0, st);
    @(posedge clk); #1; trap = 1'b1;
    @(posedge clk); #1; trap = 1'b0;
    do_op(F_SC, 32'h200, 32'h77, 0, st);
    chk("trap_sc_result", amo_result, 32'h1);

    // AMO operation table
    run_alu("min",  F_MIN,  32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF);
    run_alu("minu", F_MINU, 32'hFFFFFFFF, 32'h1, 32'h00000001);
    run_alu("maxu", F_MAXU, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF);
    run_alu("max",  F_MAX,  32'hF0F000FF, 32'h0FF00F0F, 32'h0FF00F0F);
    run_alu("xor",  F_XOR,  32'hF0F000FF, 32'h0FF00F0F, 32'hFF000FF0);
    run_alu("and",  F_AND,  32'hF0F000FF, 32'h0FF00F0F, 32'h00F0000F);
    run_alu("or",   F_OR,   32'hF0F000FF, 32'h0FF00F0F, 32'hFFF00FFF);
    run_alu("swap", F_SWAP, 32'hF0F000FF, 32'h12345678, 32'h12345678);
    run_alu("addw", F_ADD,  32'hFFFFFFFF, 32'h2, 32'h00000001);

    // Slow memory and external freeze in DONE
    ack_delay = 4;
    mem[32'h400 >> 2] = 32'd10;
    do_op(F_ADD, 32'h400, 32'd3, 2, st);
    chk("slow_stall", st, 11);
    chk("slow_result", amo_result, 32'd10);
    chk("slow_mem", mem[32'h400 >> 2], 32'd13);
    chk("slow_nrd", n_rd, 1);
    chk("slow_nwr", n_wr, 1);
    chk("slow_stable", n_unst, 0);

    // Misaligned atomic
    ack_delay = 0;
    @(posedge clk); #1;
    clr_cnt();
    is_atomic_mem = 1'b1; amo_fun5_mem = F_SWAP; addr_mem = 32'h102; rs2_data_mem = 32'h1;
    @(negedge clk); #1;
    chk("mis_flag", {31'b0, amo_misaligned}, 32'h1);
    chk("mis_stall", {31'b0, stall}, 32'h0);
    @(negedge clk); #1;
    chk("mis_nreq", n_req, 0);
    @(posedge clk); #1; is_atomic_mem = 1'b0;

    // Asynchronous reset during WRITE
    ack_delay = 4;
    mem[32'h500 >> 2] = 32'h11;
    @(posedge clk); #1;
    clr_cnt();
    is_atomic_mem = 1'b1; amo_fun5_mem = F_SWAP; addr_mem = 32'h500; rs2_data_mem = 32'h77;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (amo_we) break;
    end
    chk("rstw_in_write", {31'b0, amo_we}, 32'h1);
    reset_n = 1'b0; is_atomic_mem = 1'b0;
    #1;
    chk("rstw_req", {31'b0, amo_req}, 32'h0);
    chk("rstw_we", {31'b0, amo_we}, 32'h0);
    chk("rstw_wdata", amo_wdata, 32'h0);
    chk("rstw_result", amo_result, 32'h0);
    chk("rstw_stall", {31'b0, stall}, 32'h0);
    @(posedge clk); #1; reset_n = 1'b1; ack_delay = 0;
    @(negedge clk); #1;
    chk("rstw_nwr", n_wr, 0);
    chk("rstw_mem", mem[32'h500 >> 2], 32'h11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/atomic_unit.md
Name: atomic_unit

Overview:
- MEM-stage execution engine for RV32A: LR.W, SC.W and the nine AMO*.W ops.
- Drives the atomic_unit_stall input consumed by the core control path, which freezes the pipeline while the unit runs.
- Performs a read-modify-write over a req/ack data-memory port.
- Holds the single-hart LR/SC reservation and returns the rd result to writeback.

Parameters:
ADDR_WIDTH, 32, width of byte address on memory port
XLEN, 32, data width; only 32 supported

Ports:
clk  input  1  core clock
reset_n  input  1  asynchronous active-low reset
is_atomic_mem  input  1  atomic instruction present in MEM stage
amo_fun5_mem  input  5  inst[31:27] of MEM instruction
addr_mem  input  ADDR_WIDTH  effective address (rs1)
rs2_data_mem  input  XLEN  forwarded rs2 operand
store_mem  input  1  ordinary store executing in MEM (reservation snoop)
mem_advance  input  1  MEM->WB register enabled this cycle
trap  input  1  trap taken this cycle
atomic_unit_stall  output  1  hold pipeline
amo_req  output  1  memory request valid
amo_we  output  1  1=write, 0=read
amo_addr  output  ADDR_WIDTH  word-aligned request address
amo_wdata  output  XLEN  write data
amo_ack  input  1  memory accepted/completed request; read data valid same cycle
amo_rdata  input  XLEN  read data
amo_result  output  XLEN  value written to rd
amo_misaligned  output  1  addr_mem[1:0]!=0 on atomic; exception request

Behaviour:
- Opcodes (fun5):
  - 00010 LR
  - 00011 SC
  - 00001 SWAP
  - 00000 ADD
  - 00100 XOR
  - 01100 AND
  - 01000 OR
  - 10000 MIN
  - 10100 MAX
  - 11000 MINU
  - 11100 MAXU
  - Any other fun5 is treated as AMOSWAP; the decoder guarantees legality.
- States: IDLE, READ, WRITE, DONE. Reset: state=IDLE, reservation invalid, amo_result=0, amo_wdata=0, amo_req=0, amo_we=0.
- atomic_unit_stall = is_atomic_mem & ~misaligned & (state!=DONE). This is combinational, so the stall rises in the first MEM cycle.
- amo_misaligned = is_atomic_mem & (addr_mem[1:0]!=0) & state==IDLE. No memory access, no stall, reservation unchanged.
- IDLE, on an aligned atomic:
  - LR or AMO -> READ.
  - SC with a valid reservation whose word address matches -> WRITE, amo_wdata=rs2.
  - SC otherwise -> DONE, result=1.
- READ:
  - Outputs: amo_req=1, amo_we=0, amo_addr={addr[AW-1:2],2'b00}. Held until amo_ack.
  - On ack, rdata is captured into amo_result.
  - LR: sets reservation to this word address and goes to DONE.
  - AMO: registers amo_wdata = f(rdata, rs2) and goes to WRITE.
  - MIN/MAX compare signed; MINU/MAXU compare unsigned; ADD wraps mod 2^32.
- WRITE:
  - Outputs: amo_req=1, amo_we=1. Held until amo_ack, then -> DONE.
  - SC sets amo_result=0.
  - Both SC and AMO leave amo_addr, amo_wdata and amo_we stable until ack.
- DONE: stall=0 and amo_result is valid. Goes to IDLE only when mem_advance=1; otherwise holds, so the op never re-executes under an external freeze.
- Reservation:
  - Cleared by any SC (success or fail), by trap, by AMO/SC write to any address, and by store_mem to the matching word.
  - If an LR set and a clear occur in the same cycle, the clear wins.
- trap while in READ/WRITE does not abort: the memory transaction completes (non-interruptible), and only the reservation is cleared.
- amo_result holds its last value outside DONE.
- Asynchronous reset mid-operation returns to IDLE immediately; an outstanding request is dropped (amo_req=0).
- Latency with ack in the same cycle as req: AMO stall=3 cycles, LR=2, SC success=2, SC fail=1.

Test Plan:
1. AMOADD: mem[0x100]=5, rs2=7, ack immediate -> read 0x100, write 12, amo_result=5, stall high exactly 3 cycles.
2. LR 0x200 (mem=0xAB), then SC 0x200 rs2=0x55 -> LR result 0xAB; SC writes 0x55, result 0; a second SC fails with result 1 and no amo_req.
3. LR 0x200, ordinary store_mem to 0x203, SC 0x200 -> SC result 1, no write. Repeat with the store to 0x204 -> SC succeeds.
4. AMOMIN vs AMOMINU with mem=0xFFFFFFFF, rs2=1 -> MIN writes 0xFFFFFFFF, MINU writes 1; both results 0xFFFFFFFF. AMOMAXU writes 0xFFFFFFFF.
5. amo_ack delayed 4 cycles in READ and WRITE, and mem_advance held low 2 cycles in DONE -> address/data/we stable, stall released only in DONE, single read plus single write, no re-execution.
6. AMOSWAP at 0x102 -> amo_misaligned=1, stall=0, no amo_req. reset_n low during WRITE -> amo_req=0 and outputs at reset values that same cycle.
